// File: rtl/pu_seq.sv
// Multi-cycle control sequencer for the 16-bit processing unit: steps each
// instruction through fetch, decode, optional data-memory access and write-back.
module pu_seq #(
   parameter int          PCW      = 8,
   parameter int unsigned RESET_PC = 0,
   parameter int          CNTW     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic [PCW-1:0]  pc,
   output logic            ir_we,
   input  logic            dec_we,
   input  logic            dec_halt,
   input  logic            dec_dmwe,
   input  logic            dec_dms,
   output logic            dm_req,
   output logic            dm_wr,
   input  logic            dm_ack,
   output logic            rf_we,
   output logic            rf_wsel,
   output logic            halted,
   output logic            busy,
   output logic [CNTW-1:0] retired,
   output logic [2:0]      state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [PCW-1:0]  PC_ONE  = {{(PCW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   logic [2:0]      r_state;
   logic [PCW-1:0]  r_pc;
   logic [CNTW-1:0] r_retired;

   logic [2:0]      w_next;
   logic            w_retire;
   logic            w_is_store;
   logic            w_is_load;

   // A store wins when the decoder flags both a store and a load.
   assign w_is_store = dec_dmwe;
   assign w_is_load  = dec_dms & ~dec_dmwe;

   assign pc      = r_pc;
   assign retired = r_retired;
   assign state   = r_state;

   // State, PC and retired-count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC[PCW-1:0];
         r_retired <= {CNTW{1'b0}};
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_pc      <= r_pc + PC_ONE;
            r_retired <= r_retired + CNT_ONE;
         end else begin
            r_pc      <= r_pc;
            r_retired <= r_retired;
         end
      end
   end

   // Next-state selection and control-strobe decode from the current state.
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      ir_we    = 1'b0;
      dm_req   = 1'b0;
      dm_wr    = 1'b0;
      rf_we    = 1'b0;
      rf_wsel  = 1'b0;
      halted   = 1'b0;
      busy     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_next = S_FETCH;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_FETCH: begin
            busy   = 1'b1;
            ir_we  = 1'b1;
            w_next = S_DECODE;
         end
         S_DECODE: begin
            busy = 1'b1;
            if (dec_halt) begin
               w_next = S_HALT;
            end else if (dec_dmwe || dec_dms) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            busy   = 1'b1;
            dm_req = 1'b1;
            dm_wr  = w_is_store;
            if (dm_ack) begin
               if (w_is_store) begin
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end else begin
                  w_next   = S_WB;
               end
            end else begin
               w_next = S_MEM;
            end
         end
         S_WB: begin
            busy     = 1'b1;
            rf_we    = dec_we | w_is_load;
            rf_wsel  = w_is_load;
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            w_next = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
